// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller.
// ResultSrc, forwarding-select and memory-wait FSM state definitions.
package pipeline_hazard_ctrl_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: register ids, EX/MEM status in; stalls, flushes, selects out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int PCW = 32
);
   logic [4:0]     Rs1D, Rs2D;
   logic [4:0]     Rs1E, Rs2E, RdE;
   logic [4:0]     RdM, RdW;
   logic           RegWriteM, RegWriteW;
   logic [1:0]     ResultSrcE;
   logic           PCSrcE;
   logic           MemReqM, MemReadyM;

   logic           StallF, StallD, StallE, StallM;
   logic           FlushD, FlushE, FlushW;
   logic [1:0]     ForwardAE, ForwardBE;
   logic           MemErr;
   logic [PCW-1:0] StallCnt, FlushCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Count visible one cycle after the event; no backpressure.
module sat_counter #(
   parameter int PCW = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inc,
   output logic [PCW-1:0] count
);

   logic [PCW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + PCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch handling and a memory-wait FSM with timeout.
// Stall/flush/forward outputs are combinational (zero added latency); memory backpressure freezes IF..MEM.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8,
   parameter int PCW     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave hz
);

   state_t         state_q, state_d;
   logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
   logic           mem_err_q, mem_err_d;

   logic           lw_stall;
   logic           mem_miss;
   logic           timeout_hit;
   logic           mem_stall;
   logic           stall_any;
   logic           flush_any;
   logic [PCW-1:0] stall_cnt, flush_cnt;

   // MEM stage has the newer value, so it wins over WB; x0 is never forwarded.
   always_comb begin
      hz.ForwardAE = FWD_RF;
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
         hz.ForwardAE = FWD_MEM;
      end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
         hz.ForwardAE = FWD_WB;
      end

      hz.ForwardBE = FWD_RF;
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
         hz.ForwardBE = FWD_MEM;
      end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
         hz.ForwardBE = FWD_WB;
      end
   end

   assign lw_stall    = (hz.ResultSrcE == RES_MEM) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   assign mem_miss    = hz.MemReqM && !hz.MemReadyM && !mem_err_q;
   assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CW'(TIMEOUT));
   assign mem_stall   = ((state_q == RUN) && mem_miss) ||
                        ((state_q == WAIT) && !hz.MemReadyM && !timeout_hit);

   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b0;
      if (!rst_n) begin
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushW = 1'b1;
      end else if (mem_stall) begin
         // Whole front end frozen; WB gets a bubble while EX keeps its instruction.
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.StallF = lw_stall;
         hz.StallD = lw_stall;
         hz.FlushD = hz.PCSrcE;
         hz.FlushE = hz.PCSrcE | lw_stall;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         RUN: begin
            if (mem_miss) begin
               state_d    = WAIT;
               wait_cnt_d = CW'(1);
            end
         end
         WAIT: begin
            if (hz.MemReadyM) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (timeout_hit) begin
               state_d    = RUN;
               wait_cnt_d = '0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign stall_any = hz.StallF | hz.StallD | hz.StallE | hz.StallM;
   assign flush_any = rst_n & (hz.FlushD | hz.FlushE);

   sat_counter #(.PCW(PCW)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_any),
      .count (stall_cnt)
   );

   sat_counter #(.PCW(PCW)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_any),
      .count (flush_cnt)
   );

   assign hz.MemErr   = mem_err_q;
   assign hz.StallCnt = stall_cnt;
   assign hz.FlushCnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed plan steps plus random cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int CW      = 8;
   localparam int PCW     = 4;
   localparam int CMAX    = (1 << PCW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipeline_hazard_ctrl_if #(.PCW(PCW)) hz ();

   pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW), .PCW(PCW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: m_wait = consecutive cycles the current access has held the pipeline.
   int m_wait = 0;
   bit m_err  = 1'b0;
   int m_scnt = 0;
   int m_fcnt = 0;

   typedef struct {
      logic       sf, sd, se, sm, fd, fe, fw;
      logic [1:0] fa, fb;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) return 2'b10;
      if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic lw_ref();
      return hz.ResultSrcE == 2'b01 && hz.RdE != 5'd0 &&
             (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
   endfunction

   function automatic logic mem_stall_ref();
      if (m_err) return 1'b0;
      if (hz.MemReadyM) return 1'b0;
      if (m_wait == 0) return hz.MemReqM;
      return m_wait < TIMEOUT;
   endfunction

   function automatic exp_t model_outs();
      exp_t e;
      logic lw, ms;
      lw   = lw_ref();
      ms   = mem_stall_ref();
      e.fa = fwd_ref(hz.Rs1E);
      e.fb = fwd_ref(hz.Rs2E);
      if (!rst_n) begin
         {e.sf, e.sd, e.se, e.sm} = 4'b0000;
         {e.fd, e.fe, e.fw}       = 3'b111;
      end else if (ms) begin
         {e.sf, e.sd, e.se, e.sm} = 4'b1111;
         {e.fd, e.fe, e.fw}       = 3'b001;
      end else begin
         e.sf = lw; e.sd = lw; e.se = 1'b0; e.sm = 1'b0;
         e.fd = hz.PCSrcE; e.fe = hz.PCSrcE | lw; e.fw = 1'b0;
      end
      return e;
   endfunction

   task automatic check_all(input string tag);
      exp_t e;
      e = model_outs();
      chk({tag, ".StallF"},    32'(hz.StallF),    32'(e.sf));
      chk({tag, ".StallD"},    32'(hz.StallD),    32'(e.sd));
      chk({tag, ".StallE"},    32'(hz.StallE),    32'(e.se));
      chk({tag, ".StallM"},    32'(hz.StallM),    32'(e.sm));
      chk({tag, ".FlushD"},    32'(hz.FlushD),    32'(e.fd));
      chk({tag, ".FlushE"},    32'(hz.FlushE),    32'(e.fe));
      chk({tag, ".FlushW"},    32'(hz.FlushW),    32'(e.fw));
      chk({tag, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(e.fa));
      chk({tag, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(e.fb));
      chk({tag, ".MemErr"},    32'(hz.MemErr),    32'(m_err));
      chk({tag, ".StallCnt"},  32'(hz.StallCnt),  32'(m_scnt));
      chk({tag, ".FlushCnt"},  32'(hz.FlushCnt),  32'(m_fcnt));
   endtask

   // Advance the model using the inputs present before the edge, then cross the edge.
   task automatic tick();
      exp_t e;
      logic ms;
      e  = model_outs();
      ms = mem_stall_ref();
      if (rst_n) begin
         if (ms) begin
            m_wait++;
         end else begin
            if (m_wait > 0 && !hz.MemReadyM) m_err = 1'b1;
            m_wait = 0;
         end
         if ((e.sf | e.sd | e.se | e.sm) && m_scnt < CMAX) m_scnt++;
         if ((e.fd | e.fe) && m_fcnt < CMAX) m_fcnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_low();
      rst_n  = 1'b0;
      m_wait = 0;
      m_err  = 1'b0;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic clear_inputs();
      hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
      hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
      hz.ResultSrcE = RES_ALU; hz.PCSrcE = 1'b0;
      hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
   endtask

   initial begin
      int stall_cycles;

      clear_inputs();
      reset_low();
      #1;
      check_all("reset");
      chk("reset_flushW", 32'(hz.FlushW), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Forwarding priority
      hz.RdM = 5'd5; hz.RdW = 5'd5; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
      hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
      #1;
      chk("fwd_mem_A", 32'(hz.ForwardAE), 32'(2'b10));
      check_all("fwd_mem");
      hz.RegWriteM = 1'b0;
      #1;
      chk("fwd_wb_A", 32'(hz.ForwardAE), 32'(2'b01));
      check_all("fwd_wb");
      hz.RegWriteM = 1'b1; hz.RdM = 5'd0; hz.RdW = 5'd0;
      hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      #1;
      chk("fwd_x0_A", 32'(hz.ForwardAE), 32'(2'b00));
      check_all("fwd_x0");
      tick();

      // Load-use
      clear_inputs();
      hz.ResultSrcE = RES_MEM; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      #1;
      chk("lw_stallF", 32'(hz.StallF), 32'd1);
      chk("lw_flushE", 32'(hz.FlushE), 32'd1);
      check_all("lw");
      tick();
      chk("lw_stallcnt", 32'(hz.StallCnt), 32'd1);
      chk("lw_flushcnt", 32'(hz.FlushCnt), 32'd1);
      hz.RdE = 5'd0; hz.Rs2D = 5'd0;
      #1;
      chk("lw_x0_stallF", 32'(hz.StallF), 32'd0);
      check_all("lw_x0");
      tick();

      // Branch
      clear_inputs();
      hz.PCSrcE = 1'b1;
      #1;
      chk("br_flushD", 32'(hz.FlushD), 32'd1);
      check_all("br");
      tick();
      hz.PCSrcE = 1'b0;
      #1;
      chk("br_after_flushD", 32'(hz.FlushD), 32'd0);
      check_all("br_after");
      tick();

      // Three-cycle memory wait, branch resolving while frozen
      clear_inputs();
      hz.MemReqM = 1'b1;
      stall_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) hz.PCSrcE = 1'b1;
         #1;
         check_all("memwait");
         if (hz.StallM === 1'b1) stall_cycles++;
         tick();
      end
      hz.MemReadyM = 1'b1;
      #1;
      chk("memwait_release_stallM", 32'(hz.StallM), 32'd0);
      chk("memwait_release_flushD", 32'(hz.FlushD), 32'd1);
      check_all("memwait_release");
      tick();
      chk("memwait_stall_cycles", 32'(stall_cycles), 32'd3);
      clear_inputs();
      #1;
      check_all("memwait_after");
      tick();

      // Random traffic, with a reset halfway so timeouts recur
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            reset_low();
            #1;
            check_all("rand_reset");
            tick();
            rst_n = 1'b1;
         end
         hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
         hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
         hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
         hz.RdW  = 5'($urandom_range(0, 3));
         hz.RegWriteM  = 1'($urandom_range(0, 1));
         hz.RegWriteW  = 1'($urandom_range(0, 1));
         hz.ResultSrcE = 2'($urandom_range(0, 3));
         hz.MemReqM    = 1'($urandom_range(0, 1));
         hz.MemReadyM  = ($urandom_range(0, 2) == 0);
         hz.PCSrcE     = lw_ref() ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         check_all("rand");
         tick();
      end

      // Timeout with TIMEOUT=4
      clear_inputs();
      reset_low();
      #1;
      check_all("to_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hz.MemReqM = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("to_stallF", 32'(hz.StallF), (i < 4) ? 32'd1 : 32'd0);
         check_all("to");
         tick();
      end
      chk("to_memerr", 32'(hz.MemErr), 32'd1);
      #1;
      chk("to_after_err_stallF", 32'(hz.StallF), 32'd0);
      check_all("to_after_err");
      tick();

      // Asynchronous reset while waiting
      reset_low();
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_all("ar_wait");
         tick();
      end
      #2;
      reset_low();
      #1;
      chk("ar_flushD", 32'(hz.FlushD), 32'd1);
      chk("ar_flushE", 32'(hz.FlushE), 32'd1);
      chk("ar_flushW", 32'(hz.FlushW), 32'd1);
      chk("ar_stallF", 32'(hz.StallF), 32'd0);
      chk("ar_stallcnt", 32'(hz.StallCnt), 32'd0);
      chk("ar_memerr", 32'(hz.MemErr), 32'd0);
      check_all("ar");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hz.MemReadyM = 1'b1;
      #1;
      chk("zero_lat_stallF", 32'(hz.StallF), 32'd0);
      check_all("zero_lat");
      tick();
      hz.MemReqM = 1'b0;
      #1;
      check_all("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
